// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Purpose:
//   Sequences a W-bit add or subtract (W = 4*NIBBLES) through one external
//   4-bit ripple-carry adder, one nibble per cycle, LSB nibble first. Holds
//   the latched operands, the running carry, the result and the start/done
//   handshake.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request, accepted only while idle
//   sub             0: A + B + cin, 1: A - B (B inverted, carry-in forced 1)
//   cin             carry-in for add mode
//   op_a, op_b      operands, sampled on accept
//   busy            high while an operation is in progress or completing
//   done            one-cycle pulse, result/cout/ovf valid
//   result, cout    sum/difference and final carry (subtract: 1 = no borrow)
//   ovf             signed two's-complement overflow, valid with done
//   add_a, add_b,   nibble operands and carry driven to the external adder
//   add_cin
//   add_sum,        combinational response from the external adder
//   add_cout
//   chk_err         (optional) sticky flag, set when the finished result
//                   disagrees with a full-width add of the latched operands
//
// Optional feature macro: NIBBLE_SERIAL_ADD_SELFCHECK_EN (adds chk_err).
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
`ifdef NIBBLE_SERIAL_ADD_SELFCHECK_EN
    ,
    output logic                   chk_err
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    result_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [IW+1:0]   shamt;
    logic [W-1:0]    nib_mask;

    // Bit offset of the nibble being processed this cycle.
    assign shamt    = {idx, 2'b00};
    assign nib_mask = W'(4'hF) << shamt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one cycle per nibble in RUN, a single DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and nibble-by-nibble accumulation. B is stored already
    // inverted for subtract so RUN treats both modes identically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            result_r <= '0;
            carry    <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= sub ? ~op_b : op_b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result_r <= (result_r & ~nib_mask) | (W'(add_sum) << shamt);
                    carry    <= add_cout;
                    if (idx != LAST) begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and adder drive; the adder sees zeros outside RUN.
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        result  = result_r;
        cout    = carry;
        ovf     = (state == DONE) && (a_reg[W-1] == b_reg[W-1]) &&
                  (result_r[W-1] != a_reg[W-1]);
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = 4'(a_reg >> shamt);
            add_b   = 4'(b_reg >> shamt);
            add_cin = carry;
        end
    end

`ifdef NIBBLE_SERIAL_ADD_SELFCHECK_EN
    logic         init_c;
    logic         chk_sticky;
    logic [W:0]   ideal;
    logic         mismatch;

    assign ideal    = {1'b0, a_reg} + {1'b0, b_reg} + {{W{1'b0}}, init_c};
    assign mismatch = (state == DONE) && ({carry, result_r} != ideal);
    // Flag is visible in the DONE cycle itself, then held until reset.
    assign chk_err  = chk_sticky | mismatch;

    // Initial carry is kept because the carry register is consumed in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_c     <= 1'b0;
            chk_sticky <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                init_c <= sub ? 1'b1 : cin;
            end
            if (mismatch) begin
                chk_sticky <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//
// Purpose:
//   Scoreboard bench for nibble_serial_add_ctrl (NIBBLES=4). Stimulus pushes
//   the expected response computed with plain integer arithmetic; a monitor
//   pops and compares on every done pulse. Includes a behavioural RCA4bit
//   with an optional stuck-at-0 fault on SUM bit 0.
//
// Optional feature macro: NIBBLE_SERIAL_ADD_SELFCHECK_EN (checks chk_err).
// ---------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic          cin;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovf;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic [3:0]    add_sum;
    logic          add_cout;
    logic          stuck0 = 1'b0;
`ifdef NIBBLE_SERIAL_ADD_SELFCHECK_EN
    logic          chk_err;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         chk;
        int           acc;
    } exp_t;

    exp_t bs[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    logic chk_model = 1'b0;

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
`ifdef NIBBLE_SERIAL_ADD_SELFCHECK_EN
        ,
        .chk_err  (chk_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit adder with an optional SUM[0] stuck-at-0 fault.
    logic [4:0] rca_tmp;
    always_comb begin
        rca_tmp  = 5'(add_a) + 5'(add_b) + 5'(add_cin);
        add_sum  = rca_tmp[3:0];
        add_cout = rca_tmp[4];
        if (stuck0) add_sum[0] = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the operation as integer arithmetic on the operand values.
    function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic s, input logic c);
        exp_t   e;
        longint ua, ub, sa, sb, full, sres;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            full = ua - ub;
            e.co = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + longint'(c);
            e.co = (full >= (longint'(1) << W));
            sres = sa + sb + longint'(c);
        end
        e.res = full[W-1:0];
        e.ov  = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
        e.chk = chk_model;
        e.acc = 0;
        return e;
    endfunction

    // Called at a negedge; returns at the first negedge with busy low.
    task automatic waitIdle();
        for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk);
        checkOutput("wait_idle", busy, 0);
    endtask

    task automatic issueOp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic c, input exp_t e);
        waitIdle();
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        e.acc = cyc + 1;
        bs.push_back(e);
        @(negedge clk);
        checkOutput("busy_after_accept", busy, 1);
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
        issueOp(a, b, s, c, refModel(a, b, s, c));
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            checkOutput("done_expected", 32'(bs.size() > 0), 1);
            if (bs.size() > 0) begin
                e = bs.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("cout", cout, e.co);
                checkOutput("ovf", ovf, e.ov);
                checkOutput("latency", cyc - e.acc, NIB);
`ifdef NIBBLE_SERIAL_ADD_SELFCHECK_EN
                checkOutput("chk_err_done", chk_err, e.chk);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   prev;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_cout", cout, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_add", {add_a, add_b, add_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed arithmetic");
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0);
        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);

        $display("[TB] ignored start pulses while busy");
        applyStimulus(16'h0A0B, 16'h0C0D, 1'b0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        checkOutput("done_seen", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("idle_after_done", busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("no_extra_accept", busy, 0);

        $display("[TB] start held high");
        waitIdle();
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            waitIdle();
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            start = 1'b1;
            e     = refModel(op_a, op_b, sub, cin);
            e.acc = cyc + 1;
            if (k > 0) checkOutput("b2b_period", e.acc - prev, NIB + 2);
            prev = e.acc;
            bs.push_back(e);
            @(negedge clk);
        end
        start = 1'b0;

        $display("[TB] reset during run");
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_add", {add_a, add_b, add_cin}, 0);
        checkOutput("abort_done", done, 0);
        bs.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef NIBBLE_SERIAL_ADD_SELFCHECK_EN
        $display("[TB] faulty adder self-check");
        waitIdle();
        stuck0    = 1'b1;
        chk_model = 1'b1;
        e.res = 16'h0000;
        e.co  = 1'b0;
        e.ov  = 1'b0;
        e.chk = 1'b1;
        e.acc = 0;
        issueOp(16'h0001, 16'h0000, 1'b0, 1'b0, e);
        waitIdle();
        stuck0 = 1'b0;
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        waitIdle();
        checkOutput("chk_err_sticky", chk_err, 1);
`endif

        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", bs.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that computes a multi-word add/subtract by time-multiplexing one external 4-bit ripple-carry adder (RCA4bit), one nibble per cycle, LSB nibble first.
- Owns the operand registers, the carry register, the result register and the start/done handshake.
- Sits between a requester (ALU front-end or test bench) and the RCA4bit instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- sub  in  1  0 = A+B+cin; 1 = A-B (B inverted, initial carry forced to 1, cin ignored).
- cin  in  1  carry-in for add mode.
- op_a  in  W  operand A; sampled on accept.
- op_b  in  W  operand B; sampled on accept.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- result  out  W  sum/difference; held until next accept.
- cout  out  1  final carry (subtract: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.
- add_a  out  4  to RCA4bit A.
- add_b  out  4  to RCA4bit B.
- add_cin  out  1  to RCA4bit CIN.
- add_sum  in  4  from RCA4bit SUM (combinational, same cycle).
- add_cout  in  1  from RCA4bit COUT.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; busy = done = cout = ovf = 0; result = 0.
  - add_a = add_b = 0, add_cin = 0; index and carry registers = 0.
- IDLE:
  - start=1 at a rising edge latches op_a and op_b.
  - B register = sub ? ~op_b : op_b.
  - Carry register = sub ? 1 : cin; index = 0.
  - Next state RUN.
- RUN, one cycle per nibble:
  - add_a = A[4i+3:4i], add_b = Beff[4i+3:4i], add_cin = carry register.
  - At the clock edge: result[4i+3:4i] <= add_sum; carry <= add_cout; i <= i+1.
  - When i == NIBBLES-1, next state DONE.
- DONE (one cycle):
  - done = 1, cout = final carry.
  - ovf = (A[W-1] == Beff[W-1]) && (result[W-1] != A[W-1]).
  - Next state IDLE.
- Adder ports are driven 0 in IDLE and DONE.
- Latency: accept at edge 0; done high during cycle NIBBLES+1; throughput one operation per NIBBLES+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued. A start held high through DONE is accepted in the following IDLE cycle.
- Operand inputs may change freely after accept; only the latched copies are used.
- result and cout are updated progressively during RUN. They are valid only while done=1 and afterwards until the next accept.
- Index counter wraps only by returning to IDLE; no modular wrap inside RUN.
- NIBBLES=1: RUN lasts one cycle; done appears at cycle 2.
- Reset mid-RUN aborts the operation immediately: no done pulse, all outputs return to reset values.

Optional Feature:
- Macro NIBBLE_SERIAL_ADD_SELFCHECK_EN.
- When defined:
  - Adds output chk_err (1 bit).
  - In DONE, the controller compares {cout,result} against the ideal (W+1)-bit A + Beff + initial carry, computed from the latched operands.
  - Any mismatch sets chk_err, which stays set (sticky) until rst_n.
  - chk_err resets to 0.
- When undefined: no chk_err port and no comparator logic; all other behaviour identical.

Test Plan (NIBBLES=4):
- Add: op_a=0x1234, op_b=0x4321, cin=0, start -> done exactly at cycle 5 after accept; result=0x5555, cout=0, ovf=0.
- Carry chain: 0xFFFF+0x0001, cin=0 -> result=0x0000, cout=1, ovf=0. Also 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1.
- Subtract: sub=1, 0x0005-0x0007 -> result=0xFFFE, cout=0 (borrow), ovf=0. Also 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
- Handshake: pulse start again at cycles 2 and 5 of a busy op -> both ignored, single done pulse. Hold start high -> back-to-back ops accepted every 6 cycles.
- Reset: rst_n low at cycle 2 of an op -> busy=0, result=0, add_* = 0 same cycle; no done pulse. Next op after release completes normally.
- Self-check (macro on): adder model with SUM bit 0 stuck at 0, 0x0001+0x0000 -> result=0x0000, chk_err=1 from the done cycle, still 1 after a later correct op.
